// File: rtl/mem_stage_unit.sv
// MEM-stage access controller: issues dcache requests, stalls until dhit,
// maintains the LL/SC link register and latches HALT.
module mem_stage_unit #(
  parameter int LINK_IGN_BITS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        exmem_valid,
  input  logic        exmem_memRd,
  input  logic        exmem_memWr,
  input  logic        exmem_ll,
  input  logic        exmem_sc,
  input  logic [31:0] exmem_aluOut,
  input  logic [31:0] exmem_store,
  input  logic        exmem_regWr,
  input  logic        exmem_memToReg,
  input  logic [4:0]  exmem_regDst,
  input  logic        exmem_halt,
  input  logic [31:0] exmem_pc_add4,
  input  logic [31:0] exmem_instr,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  input  logic        ccinv,
  input  logic [31:0] ccinv_addr,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        memwb_en,
  output logic [31:0] memwb_pc_add4_in,
  output logic [31:0] memwb_instruction_in,
  output logic        memwb_regWr_in,
  output logic        memwb_memToReg_in,
  output logic [4:0]  memwb_regDst_in,
  output logic        memwb_halt_in,
  output logic [31:0] memwb_portOut_in,
  output logic [31:0] memwb_dataWriteVal_in,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HALTED = 2'd2} state_t;

  state_t      state_q;
  logic        link_valid_q;
  logic [31:0] link_addr_q;

  logic        active;
  logic        sc_fail;
  logic        req;
  logic        waiting;
  logic        xfer;
  logic        ll_done;
  logic        st_done;
  logic        link_hit_st;
  logic        link_hit_inv;
  logic [31:0] dwv;

  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return a[31:LINK_IGN_BITS] == b[31:LINK_IGN_BITS];
  endfunction

  // Request generation: a failed SC never reaches the cache
  assign active   = ~RST & (state_q != HALTED);
  assign sc_fail  = exmem_sc & ~(link_valid_q & word_match(exmem_aluOut, link_addr_q));
  assign req      = exmem_valid & (exmem_memRd | (exmem_memWr & ~sc_fail));
  assign waiting  = req & ~dhit;
  assign xfer     = active & req & dhit;

  assign dmemREN   = active & req & exmem_memRd;
  assign dmemWEN   = active & req & exmem_memWr & ~exmem_memRd;
  assign dmemaddr  = exmem_aluOut;
  assign dmemstore = exmem_store;

  assign mem_stall = ~RST & ((state_q == HALTED) | waiting);
  assign memwb_en  = active & ~waiting;
  assign halted    = (state_q == HALTED);

  always_comb begin
    dwv = exmem_store;
    if (exmem_memRd)   dwv = dmemload;
    else if (exmem_sc) dwv = {31'd0, ~sc_fail};
  end

  assign memwb_pc_add4_in      = exmem_pc_add4;
  assign memwb_instruction_in  = exmem_instr;
  assign memwb_regWr_in        = exmem_valid & exmem_regWr;
  assign memwb_memToReg_in     = exmem_memToReg;
  assign memwb_regDst_in       = exmem_regDst;
  assign memwb_halt_in         = exmem_valid & exmem_halt;
  assign memwb_portOut_in      = exmem_aluOut;
  assign memwb_dataWriteVal_in = dwv;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE, WAIT: begin
          if (memwb_en & exmem_valid & exmem_halt) state_q <= HALTED;
          else if (waiting)                        state_q <= WAIT;
          else                                     state_q <= IDLE;
        end
        HALTED:  state_q <= HALTED;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Link register: LL completion takes priority over any clearing event
  assign ll_done      = xfer & exmem_memRd & exmem_ll;
  assign st_done      = xfer & exmem_memWr & ~exmem_memRd;
  assign link_hit_st  = st_done & (exmem_sc | word_match(exmem_aluOut, link_addr_q));
  assign link_hit_inv = ccinv & word_match(ccinv_addr, link_addr_q);

  always_ff @(posedge CLK) begin
    if (RST)                              link_valid_q <= 1'b0;
    else if (ll_done)                     link_valid_q <= 1'b1;
    else if (link_hit_st | link_hit_inv)  link_valid_q <= 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (ll_done) link_addr_q <= exmem_aluOut;
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit: loads/stores with wait states, LL/SC,
// coherence invalidation, halt latching and reset during a pending access.
module tb_mem_stage_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        exmem_valid, exmem_memRd, exmem_memWr, exmem_ll, exmem_sc;
  logic [31:0] exmem_aluOut, exmem_store;
  logic        exmem_regWr, exmem_memToReg;
  logic [4:0]  exmem_regDst;
  logic        exmem_halt;
  logic [31:0] exmem_pc_add4, exmem_instr;
  logic        dhit;
  logic [31:0] dmemload;
  logic        ccinv;
  logic [31:0] ccinv_addr;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        mem_stall, memwb_en;
  logic [31:0] memwb_pc_add4_in, memwb_instruction_in;
  logic        memwb_regWr_in, memwb_memToReg_in;
  logic [4:0]  memwb_regDst_in;
  logic        memwb_halt_in;
  logic [31:0] memwb_portOut_in, memwb_dataWriteVal_in;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  mem_stage_unit #(.LINK_IGN_BITS(2)) dut (
    .CLK(CLK), .RST(RST),
    .exmem_valid(exmem_valid), .exmem_memRd(exmem_memRd), .exmem_memWr(exmem_memWr),
    .exmem_ll(exmem_ll), .exmem_sc(exmem_sc), .exmem_aluOut(exmem_aluOut),
    .exmem_store(exmem_store), .exmem_regWr(exmem_regWr), .exmem_memToReg(exmem_memToReg),
    .exmem_regDst(exmem_regDst), .exmem_halt(exmem_halt), .exmem_pc_add4(exmem_pc_add4),
    .exmem_instr(exmem_instr), .dhit(dhit), .dmemload(dmemload),
    .ccinv(ccinv), .ccinv_addr(ccinv_addr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .memwb_en(memwb_en),
    .memwb_pc_add4_in(memwb_pc_add4_in), .memwb_instruction_in(memwb_instruction_in),
    .memwb_regWr_in(memwb_regWr_in), .memwb_memToReg_in(memwb_memToReg_in),
    .memwb_regDst_in(memwb_regDst_in), .memwb_halt_in(memwb_halt_in),
    .memwb_portOut_in(memwb_portOut_in), .memwb_dataWriteVal_in(memwb_dataWriteVal_in),
    .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 3 units later.
  task automatic go();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_in();
    exmem_valid = 0; exmem_memRd = 0; exmem_memWr = 0; exmem_ll = 0; exmem_sc = 0;
    exmem_aluOut = 0; exmem_store = 0; exmem_regWr = 0; exmem_memToReg = 0;
    exmem_regDst = 0; exmem_halt = 0; exmem_pc_add4 = 0; exmem_instr = 0;
    dhit = 0; dmemload = 0; ccinv = 0; ccinv_addr = 0;
  endtask

  task automatic op(input logic rd, input logic wr, input logic ll, input logic sc,
                    input logic [31:0] addr, input logic [31:0] data, input logic hit);
    idle_in();
    exmem_valid = 1; exmem_memRd = rd; exmem_memWr = wr; exmem_ll = ll; exmem_sc = sc;
    exmem_aluOut = addr; exmem_store = data; dhit = hit;
    exmem_regWr = rd | sc; exmem_memToReg = rd;
  endtask

  initial begin
    idle_in();
    RST = 1;
    exmem_valid = 1; exmem_memRd = 1; exmem_aluOut = 32'h10;
    go(); go();
    settle();
    chk("rst_ren", dmemREN, 0);
    chk("rst_wen", dmemWEN, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_en", memwb_en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_link", dut.link_valid_q, 0);

    // bubble: valid=0 must suppress regWr/halt even if fields are set
    go();
    RST = 0;
    idle_in();
    exmem_regWr = 1; exmem_halt = 1; dhit = 1;
    settle();
    chk("bub_en", memwb_en, 1);
    chk("bub_regwr", memwb_regWr_in, 0);
    chk("bub_halt", memwb_halt_in, 0);
    chk("bub_stall", mem_stall, 0);
    chk("bub_ren", dmemREN, 0);

    // lw 0x100 with dhit after three stall cycles
    go();
    op(1, 0, 0, 0, 32'h100, 32'h0, 0);
    exmem_regDst = 5'd3; exmem_pc_add4 = 32'h0000_0404; exmem_instr = 32'h8C03_0100;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("lw_stall", mem_stall, 1);
      chk("lw_en", memwb_en, 0);
      chk("lw_ren", dmemREN, 1);
      chk("lw_addr", dmemaddr, 32'h100);
      go();
    end
    dhit = 1; dmemload = 32'hDEAD_BEEF;
    settle();
    chk("lw_done_stall", mem_stall, 0);
    chk("lw_done_en", memwb_en, 1);
    chk("lw_done_ren", dmemREN, 1);
    chk("lw_dwv", memwb_dataWriteVal_in, 32'hDEAD_BEEF);
    chk("lw_regdst", memwb_regDst_in, 5'd3);
    chk("lw_pc", memwb_pc_add4_in, 32'h0000_0404);
    chk("lw_instr", memwb_instruction_in, 32'h8C03_0100);
    chk("lw_port", memwb_portOut_in, 32'h100);
    chk("lw_regwr", memwb_regWr_in, 1);

    // sw 0x200, hit in the same cycle
    go();
    op(0, 1, 0, 0, 32'h200, 32'h1234_5678, 1);
    settle();
    chk("sw_wen", dmemWEN, 1);
    chk("sw_ren", dmemREN, 0);
    chk("sw_stall", mem_stall, 0);
    chk("sw_en", memwb_en, 1);
    chk("sw_store", dmemstore, 32'h1234_5678);
    chk("sw_dwv", memwb_dataWriteVal_in, 32'h1234_5678);
    go();
    idle_in();
    settle();
    chk("sw_state_idle", mem_stall, 0);

    // ll 0x40; sc 0x40 succeeds; second sc fails
    go();
    op(1, 0, 1, 0, 32'h40, 32'h0, 1);
    settle();
    chk("ll_en", memwb_en, 1);
    go();
    chk("ll_link", dut.link_valid_q, 1);
    op(0, 1, 0, 1, 32'h40, 32'hAAAA_0000, 1);
    settle();
    chk("sc1_wen", dmemWEN, 1);
    chk("sc1_dwv", memwb_dataWriteVal_in, 1);
    go();
    chk("sc1_link_clr", dut.link_valid_q, 0);
    op(0, 1, 0, 1, 32'h40, 32'hAAAA_0000, 0);
    settle();
    chk("sc2_wen", dmemWEN, 0);
    chk("sc2_stall", mem_stall, 0);
    chk("sc2_en", memwb_en, 1);
    chk("sc2_dwv", memwb_dataWriteVal_in, 0);

    // ll; ccinv on the linked word; sc must fail
    go();
    op(1, 0, 1, 0, 32'h40, 32'h0, 1);
    go();
    idle_in();
    ccinv = 1; ccinv_addr = 32'h40;
    go();
    op(0, 1, 0, 1, 32'h40, 32'h5, 1);
    settle();
    chk("inv_sc_wen", dmemWEN, 0);
    chk("inv_sc_dwv", memwb_dataWriteVal_in, 0);

    // ll; ccinv on a neighbouring word; sc succeeds
    go();
    op(1, 0, 1, 0, 32'h40, 32'h0, 1);
    go();
    idle_in();
    ccinv = 1; ccinv_addr = 32'h44;
    go();
    op(0, 1, 0, 1, 32'h40, 32'h5, 1);
    settle();
    chk("inv44_sc_wen", dmemWEN, 1);
    chk("inv44_sc_dwv", memwb_dataWriteVal_in, 1);

    // ll completing alongside a matching ccinv keeps the link
    go();
    op(1, 0, 1, 0, 32'h40, 32'h0, 1);
    ccinv = 1; ccinv_addr = 32'h40;
    go();
    chk("ll_vs_inv_link", dut.link_valid_q, 1);

    // sw into the linked word (byte offset ignored) clears the link
    op(0, 1, 0, 0, 32'h42, 32'h9, 1);
    go();
    chk("sw_clr_link", dut.link_valid_q, 0);
    op(0, 1, 0, 1, 32'h40, 32'h5, 1);
    settle();
    chk("sw_clr_sc_wen", dmemWEN, 0);

    // reset while a lw is waiting
    go();
    op(1, 0, 1, 0, 32'h40, 32'h0, 1);
    go();
    op(1, 0, 0, 0, 32'h300, 32'h0, 0);
    settle();
    chk("wr_stall0", mem_stall, 1);
    go();
    settle();
    chk("wr_wait_ren", dmemREN, 1);
    go();
    RST = 1;
    settle();
    chk("wr_rst_ren", dmemREN, 0);
    chk("wr_rst_en", memwb_en, 0);
    chk("wr_rst_stall", mem_stall, 0);
    go();
    RST = 0;
    idle_in();
    chk("wr_state", 32'(dut.state_q), 32'd0);
    chk("wr_link", dut.link_valid_q, 0);
    settle();
    chk("wr_after_ren", dmemREN, 0);

    // halt, then everything frozen
    go();
    idle_in();
    exmem_valid = 1; exmem_halt = 1;
    settle();
    chk("halt_en", memwb_en, 1);
    chk("halt_in", memwb_halt_in, 1);
    chk("halt_not_yet", halted, 0);
    go();
    for (int i = 0; i < 12; i++) begin
      op(i[0] ? 1'b0 : 1'b1, i[0], 0, 0, 32'h500 + 32'(i), 32'h77, i[1]);
      settle();
      chk("hlt_halted", halted, 1);
      chk("hlt_ren", dmemREN, 0);
      chk("hlt_wen", dmemWEN, 0);
      chk("hlt_en", memwb_en, 0);
      chk("hlt_stall", mem_stall, 1);
      go();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
